// File: rtl/scaler_vin_lpad.sv
// Scaler input vertical line-alignment stage: forwards input lines, then drives scaler_pad
// to append zero lines until the frame line count is a multiple of LINE_ALIGN.
module scaler_vin_lpad #(
  parameter int unsigned PIXEL_BITWIDTH    = 8,
  parameter int unsigned PIXEL_NUM         = 2,
  parameter int unsigned IMG_H_MAX         = 3840,
  parameter int unsigned IMG_H_BITWIDTH    = $clog2(IMG_H_MAX),
  parameter int unsigned LINE_ALIGN        = 4,
  parameter int unsigned LINE_CNT_BITWIDTH = 12
) (
  input  logic                                   s_clk,
  input  logic                                   s_rst_n,
  input  logic [IMG_H_BITWIDTH-1:0]              len,
  input  logic                                   s_axis_valid,
  input  logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0]    s_axis_pixel,
  input  logic                                   s_axis_user,
  input  logic                                   s_axis_last,
  input  logic                                   s_axis_eof,
  output logic                                   pad_start,
  output logic [IMG_H_BITWIDTH-1:0]              pad_len,
  input  logic                                   pad_valid,
  input  logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0]    pad_pixel,
  input  logic                                   pad_done,
  output logic                                   m_axis_valid,
  output logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0]    m_axis_pixel,
  output logic                                   m_axis_user,
  output logic                                   m_axis_last,
  output logic [LINE_CNT_BITWIDTH-1:0]           line_cnt,
  output logic                                   frame_done,
  output logic                                   drop_err
);

  localparam int unsigned PixW   = PIXEL_BITWIDTH * PIXEL_NUM;
  localparam int unsigned AlignW = (LINE_ALIGN > 1) ? $clog2(LINE_ALIGN) : 1;
  localparam logic [AlignW-1:0] AlignLast = AlignW'(LINE_ALIGN - 1);
  localparam logic [AlignW-1:0] AlignMod  = AlignW'(LINE_ALIGN);

  typedef enum logic [2:0] {StIdle, StPass, StPadReq, StPadWait, StDone} state_e;

  state_e                        state_q, state_d;
  logic [IMG_H_BITWIDTH-1:0]     len_q, len_d;
  logic [IMG_H_BITWIDTH-1:0]     beat_q, beat_d;
  logic [AlignW-1:0]             align_q, align_d;
  logic [AlignW-1:0]             remain_q, remain_d;
  logic [LINE_CNT_BITWIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic                          padded_q, padded_d;
  logic                          m_valid_q, m_valid_d;
  logic [PixW-1:0]               m_pixel_q, m_pixel_d;
  logic                          m_user_q, m_user_d;
  logic                          m_last_q, m_last_d;
  logic                          frame_done_q, frame_done_d;
  logic                          drop_err_q, drop_err_d;

  logic                          take;
  logic [LINE_CNT_BITWIDTH-1:0]  line_base;
  logic [AlignW-1:0]             align_base;
  logic [AlignW-1:0]             align_inc;
  logic [IMG_H_BITWIDTH-1:0]     len_eff;

  function automatic logic [LINE_CNT_BITWIDTH-1:0] sat_inc(
    input logic [LINE_CNT_BITWIDTH-1:0] v
  );
    return (v == '1) ? v : v + LINE_CNT_BITWIDTH'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    align_d      = align_q;
    remain_d     = remain_q;
    line_cnt_d   = line_cnt_q;
    padded_d     = padded_q;
    m_valid_d    = 1'b0;
    m_pixel_d    = m_pixel_q;
    m_user_d     = 1'b0;
    m_last_d     = 1'b0;
    frame_done_d = 1'b0;
    drop_err_d   = 1'b0;
    take         = 1'b0;
    line_base    = line_cnt_q;
    align_base   = align_q;
    align_inc    = '0;
    len_eff      = len_q;

    unique case (state_q)
      StIdle: begin
        // Non-SOF beats are discarded silently while idle
        if (s_axis_valid && s_axis_user) begin
          take       = 1'b1;
          line_base  = '0;
          align_base = '0;
          len_eff    = len;
          len_d      = len;
          m_user_d   = 1'b1;
          state_d    = StPass;
        end
      end
      StPass: begin
        take = s_axis_valid;
      end
      StPadReq: begin
        drop_err_d = s_axis_valid;
        beat_d     = '0;
        state_d    = StPadWait;
      end
      StPadWait: begin
        drop_err_d = s_axis_valid;
        if (pad_valid) begin
          m_valid_d = 1'b1;
          m_pixel_d = pad_pixel;
          m_last_d  = (beat_q == len_q - IMG_H_BITWIDTH'(1));
          beat_d    = beat_q + IMG_H_BITWIDTH'(1);
          if (m_last_d) begin
            line_cnt_d = sat_inc(line_cnt_q);
          end
        end
        if (pad_done) begin
          remain_d = remain_q - AlignW'(1);
          if (remain_q == AlignW'(1)) begin
            // Pulse here so frame_done lands one cycle after the final last beat
            frame_done_d = 1'b1;
            state_d      = StDone;
          end else begin
            state_d = StPadReq;
          end
        end
      end
      StDone: begin
        drop_err_d   = s_axis_valid;
        frame_done_d = !padded_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      m_valid_d  = 1'b1;
      m_pixel_d  = s_axis_pixel;
      m_last_d   = s_axis_last;
      line_cnt_d = line_base;
      align_d    = align_base;
      if (s_axis_last) begin
        align_inc  = (align_base == AlignLast) ? '0 : align_base + AlignW'(1);
        line_cnt_d = sat_inc(line_base);
        align_d    = align_inc;
        if (s_axis_eof) begin
          if (align_inc == '0 || LINE_ALIGN == 1 || len_eff == '0) begin
            padded_d = 1'b0;
            state_d  = StDone;
          end else begin
            padded_d = 1'b1;
            remain_d = AlignMod - align_inc;
            state_d  = StPadReq;
          end
        end
      end
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      beat_q       <= '0;
      align_q      <= '0;
      remain_q     <= '0;
      line_cnt_q   <= '0;
      padded_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      m_pixel_q    <= '0;
      m_user_q     <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      align_q      <= align_d;
      remain_q     <= remain_d;
      line_cnt_q   <= line_cnt_d;
      padded_q     <= padded_d;
      m_valid_q    <= m_valid_d;
      m_pixel_q    <= m_pixel_d;
      m_user_q     <= m_user_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign pad_start    = (state_q == StPadReq);
  assign pad_len      = len_q;
  assign m_axis_valid = m_valid_q;
  assign m_axis_pixel = m_pixel_q;
  assign m_axis_user  = m_user_q;
  assign m_axis_last  = m_last_q;
  assign line_cnt     = line_cnt_q;
  assign frame_done   = frame_done_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_scaler_vin_lpad.sv
// Bench for scaler_vin_lpad: two instances (LINE_ALIGN 4 and 1), a behavioural scaler_pad,
// and a scoreboard of expected output beats built from the frame/padding arithmetic.
module tb_scaler_vin_lpad;

  typedef struct {
    logic [15:0] pix;
    logic        user;
    logic        last;
    int          lc;
  } beat_t;

  logic        s_clk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        tb_rst_n = 1'b0;
  logic [11:0] len = '0;
  logic        s_valid = 1'b0;
  logic [15:0] s_pixel = '0;
  logic        s_user = 1'b0;
  logic        s_last = 1'b0;
  logic        s_eof = 1'b0;
  logic        sel1 = 1'b0;

  logic [1:0]  in_valid_w;
  logic [1:0]  pad_start_w, pad_valid_w, pad_done_w;
  logic [1:0]  m_valid_w, m_user_w, m_last_w, fd_w, drop_w;
  logic [11:0] pad_len_w [2];
  logic [15:0] m_pix_w [2];
  logic [11:0] lc_w [2];
  logic [15:0] pad_pix_w = 16'h0000;

  int la [2] = '{4, 1};
  int pad_rem [2];
  logic [1:0] pad_fin;

  beat_t q0[$];
  beat_t q1[$];
  int exp_lines [2];
  int exp_len [2];
  int ps_cnt [2], fd_cnt [2], drop_cnt [2], fd_cyc [2], lc_fd [2], last_cyc [2];
  int cyc = 0;
  int eof_cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 s_clk = ~s_clk;
  always @(posedge s_clk) cyc <= cyc + 1;

  assign in_valid_w[0] = s_valid & ~sel1;
  assign in_valid_w[1] = s_valid & sel1;

  scaler_vin_lpad #(.LINE_ALIGN(4)) u_dut0 (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .len(len),
    .s_axis_valid(in_valid_w[0]), .s_axis_pixel(s_pixel), .s_axis_user(s_user),
    .s_axis_last(s_last), .s_axis_eof(s_eof),
    .pad_start(pad_start_w[0]), .pad_len(pad_len_w[0]), .pad_valid(pad_valid_w[0]),
    .pad_pixel(pad_pix_w), .pad_done(pad_done_w[0]),
    .m_axis_valid(m_valid_w[0]), .m_axis_pixel(m_pix_w[0]), .m_axis_user(m_user_w[0]),
    .m_axis_last(m_last_w[0]), .line_cnt(lc_w[0]), .frame_done(fd_w[0]), .drop_err(drop_w[0])
  );

  scaler_vin_lpad #(.LINE_ALIGN(1)) u_dut1 (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .len(len),
    .s_axis_valid(in_valid_w[1]), .s_axis_pixel(s_pixel), .s_axis_user(s_user),
    .s_axis_last(s_last), .s_axis_eof(s_eof),
    .pad_start(pad_start_w[1]), .pad_len(pad_len_w[1]), .pad_valid(pad_valid_w[1]),
    .pad_pixel(pad_pix_w), .pad_done(pad_done_w[1]),
    .m_axis_valid(m_valid_w[1]), .m_axis_pixel(m_pix_w[1]), .m_axis_user(m_user_w[1]),
    .m_axis_last(m_last_w[1]), .line_cnt(lc_w[1]), .frame_done(fd_w[1]), .drop_err(drop_w[1])
  );

  // scaler_pad stand-in; not tied to s_rst_n so in-flight beats outlive a DUT reset
  always @(posedge s_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      pad_rem <= '{0, 0};
      pad_fin <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pad_start_w[i]) begin
          pad_rem[i] <= int'(pad_len_w[i]);
          pad_fin[i] <= 1'b0;
        end else if (pad_rem[i] != 0) begin
          pad_rem[i] <= pad_rem[i] - 1;
          pad_fin[i] <= (pad_rem[i] == 1);
        end else begin
          pad_fin[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pad_valid_w = '0;
    pad_done_w  = '0;
    for (int i = 0; i < 2; i++) begin
      pad_valid_w[i] = (pad_rem[i] != 0);
      pad_done_w[i]  = pad_fin[i];
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int i, input beat_t b);
    if (i == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  // Single compare process for both instances
  always @(negedge s_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid_w[i]) begin
        if (qsize(i) == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: inst %0d got pixel %0h expected no beat", i, m_pix_w[i]);
        end else begin
          beat_t e;
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("beat_pixel", m_pix_w[i], e.pix);
          chk("beat_user", m_user_w[i], e.user);
          chk("beat_last", m_last_w[i], e.last);
          if (e.last) begin
            chk("line_cnt_on_last", lc_w[i], e.lc);
            last_cyc[i] = cyc;
          end
        end
      end
      if (pad_start_w[i]) begin
        ps_cnt[i]++;
        chk("pad_len", pad_len_w[i], exp_len[i]);
      end
      if (drop_w[i]) drop_cnt[i]++;
      if (fd_w[i]) begin
        fd_cnt[i]++;
        fd_cyc[i] = cyc;
        lc_fd[i]  = int'(lc_w[i]);
        chk("fd_queue_empty", qsize(i), 0);
        chk("fd_after_last", cyc, last_cyc[i] + 1);
        chk("fd_line_cnt", lc_w[i], exp_lines[i]);
      end
    end
  end

  // Drive a frame; push its beats plus the computed pad lines into the scoreboard
  task automatic send_frame(input int inst, input int nl, input int lb, input int lenv,
                            input int fid);
    int a;
    int npad;
    beat_t b;
    sel1 = (inst == 1);
    exp_len[inst] = lenv;
    for (int l = 0; l < nl; l++) begin
      for (int k = 0; k < lb; k++) begin
        @(posedge s_clk);
        #1;
        s_valid = 1'b1;
        s_user  = (l == 0 && k == 0);
        s_last  = (k == lb - 1);
        s_eof   = (l == nl - 1 && k == lb - 1);
        s_pixel = 16'(fid * 4096 + l * 16 + k + 1);
        // len is only sampled on SOF; scramble it afterwards
        len     = (l == 0 && k == 0) ? 12'(lenv) : 12'h5a5;
        if (s_eof) eof_cyc = cyc;
        b.pix  = s_pixel;
        b.user = s_user;
        b.last = s_last;
        b.lc   = l + 1;
        qpush(inst, b);
      end
    end
    @(posedge s_clk);
    #1;
    s_valid = 1'b0;
    s_user  = 1'b0;
    s_last  = 1'b0;
    s_eof   = 1'b0;
    a    = nl % la[inst];
    npad = (a == 0 || la[inst] == 1 || lenv == 0) ? 0 : la[inst] - a;
    for (int p = 0; p < npad; p++) begin
      for (int k = 0; k < lenv; k++) begin
        b.pix  = 16'h0000;
        b.user = 1'b0;
        b.last = (k == lenv - 1);
        b.lc   = nl + p + 1;
        qpush(inst, b);
      end
    end
    exp_lines[inst] = nl + npad;
  endtask

  task automatic wait_frame(input int inst);
    int start;
    int n;
    start = fd_cnt[inst];
    n = 0;
    while (fd_cnt[inst] == start && n < 2000) begin
      @(posedge s_clk);
      n++;
    end
    if (fd_cnt[inst] == start) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic wait_pad_start(input int inst);
    int start;
    int n;
    start = ps_cnt[inst];
    n = 0;
    while (ps_cnt[inst] == start && n < 500) begin
      @(posedge s_clk);
      n++;
    end
    if (ps_cnt[inst] == start) chk("pad_start_timeout", 0, 1);
  endtask

  initial begin
    int ps0;
    int fd0;
    #2;
    chk("rst_m_valid", m_valid_w[0], 0);
    chk("rst_pad_start", pad_start_w[0], 0);
    chk("rst_line_cnt", lc_w[0], 0);
    chk("rst_frame_done", fd_w[0], 0);
    repeat (3) @(posedge s_clk);
    #3;
    tb_rst_n = 1'b1;
    s_rst_n  = 1'b1;

    // 6 lines, len 8 -> 2 pad lines
    ps0 = ps_cnt[0];
    fd0 = fd_cnt[0];
    send_frame(0, 6, 8, 8, 1);
    chk("model_lines_6", exp_lines[0], 8);
    wait_frame(0);
    chk("t1_pad_starts", ps_cnt[0] - ps0, 2);
    chk("t1_frame_dones", fd_cnt[0] - fd0, 1);
    chk("t1_line_cnt", lc_fd[0], 8);

    // 8 lines -> no padding, frame_done two cycles after eof beat
    ps0 = ps_cnt[0];
    send_frame(0, 8, 8, 8, 2);
    wait_frame(0);
    chk("t2_pad_starts", ps_cnt[0] - ps0, 0);
    chk("t2_fd_latency", fd_cyc[0] - eof_cyc, 2);
    chk("t2_line_cnt", lc_fd[0], 8);

    // LINE_ALIGN=1, 5 lines
    send_frame(1, 5, 8, 8, 3);
    wait_frame(1);
    chk("t3a_pad_starts", ps_cnt[1], 0);
    chk("t3a_line_cnt", lc_fd[1], 5);
    chk("t3a_fd_latency", fd_cyc[1] - eof_cyc, 2);

    // len 0, 3 lines -> no padding
    ps0 = ps_cnt[0];
    send_frame(0, 3, 4, 0, 4);
    wait_frame(0);
    chk("t3b_pad_starts", ps_cnt[0] - ps0, 0);
    chk("t3b_line_cnt", lc_fd[0], 3);

    // Beat injected during PAD_WAIT is dropped
    ps0 = ps_cnt[0];
    send_frame(0, 5, 8, 8, 5);
    chk("model_lines_5", exp_lines[0], 8);
    wait_pad_start(0);
    repeat (3) @(posedge s_clk);
    #1;
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_eof   = 1'b1;
    s_pixel = 16'hdead;
    @(posedge s_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_eof   = 1'b0;
    wait_frame(0);
    chk("t4_drop_cnt", drop_cnt[0], 1);
    chk("t4_pad_starts", ps_cnt[0] - ps0, 3);
    chk("t4_line_cnt", lc_fd[0], 8);

    // Reset in the middle of the first pad line
    send_frame(0, 6, 8, 8, 6);
    wait_pad_start(0);
    repeat (4) @(posedge s_clk);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid_w[0], 0);
    chk("mid_rst_m_pixel", m_pix_w[0], 0);
    chk("mid_rst_m_last", m_last_w[0], 0);
    chk("mid_rst_line_cnt", lc_w[0], 0);
    chk("mid_rst_pad_start", pad_start_w[0], 0);
    chk("mid_rst_pad_len", pad_len_w[0], 0);
    q0.delete();
    @(posedge s_clk);
    #3;
    s_rst_n = 1'b1;
    fd0 = fd_cnt[0];
    send_frame(0, 4, 8, 8, 7);
    wait_frame(0);
    chk("t5_frame_dones", fd_cnt[0] - fd0, 1);
    chk("t5_line_cnt", lc_fd[0], 4);

    // Back-to-back frames: 3 lines then 5 lines
    ps0 = ps_cnt[0];
    send_frame(0, 3, 8, 8, 8);
    wait_frame(0);
    chk("t6a_pad_starts", ps_cnt[0] - ps0, 1);
    chk("t6a_line_cnt", lc_fd[0], 4);
    ps0 = ps_cnt[0];
    send_frame(0, 5, 8, 8, 9);
    wait_frame(0);
    chk("t6b_pad_starts", ps_cnt[0] - ps0, 3);
    chk("t6b_line_cnt", lc_fd[0], 8);

    repeat (5) @(posedge s_clk);
    chk("total_drops", drop_cnt[0] + drop_cnt[1], 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
